// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Each serial bit is held for OVERSAMPLE tx_clk cycles.
module uart_tx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic [3:0] length,
  input  logic       parity_type,
  input  logic       parity_en,
  input  logic       stop2,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       last_bit_q, last_bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bit_q, par_bit_d;
  logic             par_en_q, par_en_d;
  logic             stop2_q, stop2_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             len_ok_c;
  logic             bit_end_c;
  logic [CNT_W-1:0] cnt_next_c;

  // Parity over data[len-1:0] only; unused upper bits are masked off.
  function automatic logic calc_parity(input logic [7:0] data, input logic [3:0] len,
                                       input logic ptype);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      d[i] = data[i] & (4'(i) < len);
    end
    return ptype ? ^d : ~^d;
  endfunction

  assign len_ok_c   = (length >= 4'd5) && (length <= 4'd8);
  assign bit_end_c  = (cnt_q == CNT_MAX);
  assign cnt_next_c = bit_end_c ? '0 : cnt_q + CNT_W'(1);

  // Next-state and next-output logic; tx_d always reflects the bit of the state being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    last_bit_d = last_bit_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (tx_start) begin
          if (len_ok_c) begin
            shift_d    = tx_data;
            last_bit_d = 3'(length - 4'd1);
            par_bit_d  = calc_parity(tx_data, length, parity_type);
            par_en_d   = parity_en;
            stop2_d    = stop2;
            state_d    = S_START;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_START: begin
        cnt_d = cnt_next_c;
        if (bit_end_c) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        cnt_d = cnt_next_c;
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == last_bit_q) begin
            bit_cnt_d = '0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP1;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        cnt_d = cnt_next_c;
        if (bit_end_c) begin
          state_d = S_STOP1;
          tx_d    = 1'b1;
        end
      end
      S_STOP1: begin
        cnt_d = cnt_next_c;
        tx_d  = 1'b1;
        if (bit_end_c) begin
          if (stop2_q) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_STOP2: begin
        cnt_d = cnt_next_c;
        tx_d  = 1'b1;
        if (bit_end_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      last_bit_q <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      last_bit_q <= last_bit_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign tx_err  = err_q;

endmodule
